// File: rtl/core_types_pkg.sv
// Shared core types: active-list/queue geometry, id and register typedefs,
// and the per-entry metadata carried from dispatch to retirement.
package core_types_pkg;
  localparam int AL_DEPTH = 64;
  localparam int AL_W     = $clog2(AL_DEPTH);
  localparam int LQ_DEPTH = 16;
  localparam int LQ_W     = $clog2(LQ_DEPTH);
  localparam int SQ_DEPTH = 16;
  localparam int SQ_W     = $clog2(SQ_DEPTH);
  localparam int BR_DEPTH = 8;
  localparam int BR_W     = $clog2(BR_DEPTH);
  localparam int PHYS_W   = 7;

  typedef logic [AL_W-1:0]   al_id_t;
  typedef logic [PHYS_W-1:0] phys_reg_t;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      is_branch;
    logic      uses_rw;
    phys_reg_t old_phys;
  } al_entry_meta_t;

  // Age of an id relative to a base, modulo the active-list depth.
  function automatic al_id_t al_offset(al_id_t id, al_id_t base);
    return id - base;
  endfunction
endpackage

// File: rtl/commit_retire_unit_if.sv
// Dispatch/completion/flush inputs and commit outputs of the retire unit.
interface commit_retire_unit_if;
  import core_types_pkg::*;

  logic      alloc_valid;
  logic      alloc_is_load;
  logic      alloc_is_store;
  logic      alloc_is_branch;
  logic      alloc_uses_rw;
  phys_reg_t alloc_old_phys;
  logic      int_done_valid;
  al_id_t    int_done_id;
  logic      mem_done_valid;
  al_id_t    mem_done_id;
  logic      flush_valid;
  al_id_t    flush_tail_id;
  logic      store_ready;

  al_id_t    alloc_id;
  logic      al_full;
  logic      al_empty;
  logic      commit_valid;
  al_id_t    commit_id;
  logic      free_valid;
  phys_reg_t free_phys;
  logic      load_done;
  logic      store_done;
  logic      branch_done;
  al_id_t    oldest_ptr;
  logic [LQ_W-1:0] load_commit_ptr;
  logic [SQ_W-1:0] store_commit_ptr;
  logic [BR_W-1:0] branch_read_ptr;

  modport master (
    output alloc_valid, alloc_is_load, alloc_is_store, alloc_is_branch,
           alloc_uses_rw, alloc_old_phys, int_done_valid, int_done_id,
           mem_done_valid, mem_done_id, flush_valid, flush_tail_id, store_ready,
    input  alloc_id, al_full, al_empty, commit_valid, commit_id, free_valid,
           free_phys, load_done, store_done, branch_done, oldest_ptr,
           load_commit_ptr, store_commit_ptr, branch_read_ptr
  );

  modport slave (
    input  alloc_valid, alloc_is_load, alloc_is_store, alloc_is_branch,
           alloc_uses_rw, alloc_old_phys, int_done_valid, int_done_id,
           mem_done_valid, mem_done_id, flush_valid, flush_tail_id, store_ready,
    output alloc_id, al_full, al_empty, commit_valid, commit_id, free_valid,
           free_phys, load_done, store_done, branch_done, oldest_ptr,
           load_commit_ptr, store_commit_ptr, branch_read_ptr
  );
endinterface

// File: rtl/wrap_ptr.sv
// Wrapping pointer: W index bits plus a colour MSB; load beats increment.
module wrap_ptr #(
  parameter int W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       ld_i,
  input  logic [W:0] ld_val_i,
  output logic [W:0] ptr_o
);
  logic [W:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (ld_i)       ptr_d = ld_val_i;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/commit_retire_unit.sv
// In-order retirement over the active list: tracks valid/ready per entry,
// retires one head entry per cycle and rolls the tail back on branch miss.
module commit_retire_unit
  import core_types_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  commit_retire_unit_if.slave  bus
);
  logic [AL_W:0]       head, tail, tail_ld, occ;
  logic [LQ_W:0]       lq_ptr;
  logic [SQ_W:0]       sq_ptr;
  logic [BR_W:0]       br_ptr;
  logic [AL_DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, squash;
  al_entry_meta_t      meta_q [AL_DEPTH];
  al_entry_meta_t      hmeta, alloc_meta;
  al_id_t              head_idx, tail_idx, keep;
  logic                full, empty, retire, flush_go, alloc_go;
  logic                unused_colour;

  logic      commit_valid_q, free_valid_q, load_done_q, store_done_q, branch_done_q;
  al_id_t    commit_id_q;
  phys_reg_t free_phys_q;

  assign head_idx = head[AL_W-1:0];
  assign tail_idx = tail[AL_W-1:0];
  assign occ      = tail - head;
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[AL_W] != tail[AL_W]);
  assign hmeta    = meta_q[head_idx];

  assign retire   = valid_q[head_idx] && ready_q[head_idx] &&
                    (!hmeta.is_store || bus.store_ready);
  assign flush_go = bus.flush_valid && (bus.flush_tail_id != tail_idx);
  // Alloc may reuse the slot the head vacates this cycle, so full is no barrier then.
  assign alloc_go = bus.alloc_valid && !bus.flush_valid && (!full || retire);

  // New tail keeps (flush_tail_id - head) entries, which fixes its colour.
  assign keep    = bus.flush_tail_id - head_idx;
  assign tail_ld = head + {1'b0, keep};

  for (genvar g = 0; g < AL_DEPTH; g++) begin : g_squash
    assign squash[g] = flush_go &&
                       (al_offset(al_id_t'(g), head_idx) >= keep) &&
                       ({1'b0, al_offset(al_id_t'(g), head_idx)} < occ);
  end

  assign alloc_meta = '{is_load:   bus.alloc_is_load,
                        is_store:  bus.alloc_is_store,
                        is_branch: bus.alloc_is_branch,
                        uses_rw:   bus.alloc_uses_rw,
                        old_phys:  bus.alloc_old_phys};

  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    if (bus.int_done_valid && valid_q[bus.int_done_id]) ready_d[bus.int_done_id] = 1'b1;
    if (bus.mem_done_valid && valid_q[bus.mem_done_id]) ready_d[bus.mem_done_id] = 1'b1;
    if (retire) begin
      valid_d[head_idx] = 1'b0;
      ready_d[head_idx] = 1'b0;
    end
    valid_d = valid_d & ~squash;
    ready_d = ready_d & ~squash;
    if (alloc_go) begin
      valid_d[tail_idx] = 1'b1;
      ready_d[tail_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < AL_DEPTH; i++) meta_q[i] <= '0;
    end else if (alloc_go) begin
      meta_q[tail_idx] <= alloc_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      free_valid_q   <= 1'b0;
      free_phys_q    <= '0;
      load_done_q    <= 1'b0;
      store_done_q   <= 1'b0;
      branch_done_q  <= 1'b0;
    end else begin
      commit_valid_q <= retire;
      free_valid_q   <= retire && hmeta.uses_rw;
      load_done_q    <= retire && hmeta.is_load;
      store_done_q   <= retire && hmeta.is_store;
      branch_done_q  <= retire && hmeta.is_branch;
      if (retire) begin
        commit_id_q <= head_idx;
        free_phys_q <= hmeta.old_phys;
      end
    end
  end

  wrap_ptr #(.W(AL_W)) u_head (.clk(clk), .rst(rst), .inc_i(retire), .ld_i(1'b0),
                               .ld_val_i('0), .ptr_o(head));
  wrap_ptr #(.W(AL_W)) u_tail (.clk(clk), .rst(rst), .inc_i(alloc_go), .ld_i(flush_go),
                               .ld_val_i(tail_ld), .ptr_o(tail));
  wrap_ptr #(.W(LQ_W)) u_lq (.clk(clk), .rst(rst), .inc_i(retire && hmeta.is_load),
                             .ld_i(1'b0), .ld_val_i('0), .ptr_o(lq_ptr));
  wrap_ptr #(.W(SQ_W)) u_sq (.clk(clk), .rst(rst), .inc_i(retire && hmeta.is_store),
                             .ld_i(1'b0), .ld_val_i('0), .ptr_o(sq_ptr));
  wrap_ptr #(.W(BR_W)) u_br (.clk(clk), .rst(rst), .inc_i(retire && hmeta.is_branch),
                             .ld_i(1'b0), .ld_val_i('0), .ptr_o(br_ptr));

  // Queue pointers only need their index; the colour bit is intentionally dropped.
  assign unused_colour = ^{lq_ptr[LQ_W], sq_ptr[SQ_W], br_ptr[BR_W]};

  assign bus.alloc_id         = tail_idx;
  assign bus.al_full          = full;
  assign bus.al_empty         = empty;
  assign bus.commit_valid     = commit_valid_q;
  assign bus.commit_id        = commit_id_q;
  assign bus.free_valid       = free_valid_q;
  assign bus.free_phys        = free_phys_q;
  assign bus.load_done        = load_done_q;
  assign bus.store_done       = store_done_q;
  assign bus.branch_done      = branch_done_q;
  assign bus.oldest_ptr       = head_idx;
  assign bus.load_commit_ptr  = lq_ptr[LQ_W-1:0];
  assign bus.store_commit_ptr = sq_ptr[SQ_W-1:0];
  assign bus.branch_read_ptr  = br_ptr[BR_W-1:0];
endmodule
